ping_sequencer: RTL
===================

PING_SEQUENCER -- requirements
Module: ping_sequencer

Interface
REQ-001 SHALL have parameter TX_CYCLES, default 150, meaning transmit-burst length in clocks (1..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1500, meaning post-transmit blanking length in clocks (0..65535).
REQ-003 SHALL have parameter LISTEN_CYCLES, default 120000, meaning receive-window length in clocks (1..2^20-1).
REQ-004 SHALL have one clock and asynchronous active-high reset:
- clk_in  input  1  system clock, 150 MHz
- rst_in  input  1  reset, asynchronous, active-high
REQ-005 SHALL have the following other ports:
- enable_in  input  1  when high, triggers in IDLE start a sequence
- trigger_in  input  1  single-cycle ping request, from 1 kHz tick
- abort_in  input  1  cancels any sequence in progress
- drain_done_in  input  1  consumer has emptied captured frame
- tx_en_out  output  1  transmitter burst enable
- capture_en_out  output  1  receive-datapath capture enable
- busy_out  output  1  sequence in progress
- done_out  output  1  one-cycle pulse on sequence completion
- ping_count_out  output  16  completed sequences, wraps
- missed_count_out  output  8  triggers dropped while busy, saturating

Function
REQ-006 SHALL implement states IDLE, TX, BLANK, LISTEN, DRAIN with one shared 20-bit phase counter.
REQ-007 SHALL leave IDLE for TX on the clock edge where trigger_in=1 and enable_in=1, counter cleared to 0.
REQ-008 SHALL hold TX exactly TX_CYCLES cycles, then go to BLANK, or to LISTEN if BLANK_CYCLES=0.
REQ-009 SHALL hold BLANK exactly BLANK_CYCLES cycles, then go to LISTEN.
REQ-010 SHALL hold LISTEN exactly LISTEN_CYCLES cycles, then go to DRAIN.
REQ-011 SHALL stay in DRAIN until drain_done_in=1, then return to IDLE on that edge.
REQ-012 SHALL drive outputs from registered state only:
- tx_en_out = state TX
- capture_en_out = state LISTEN
- busy_out = state not IDLE
REQ-013 SHALL pulse done_out for exactly one cycle, the first cycle back in IDLE after DRAIN.
REQ-014 SHALL increment ping_count_out on that same edge, wrapping 65535 -> 0.
REQ-015 SHALL treat drain_done_in as don't-care outside DRAIN.
REQ-016 SHALL handle abort_in=1 in any non-IDLE state:
- go to IDLE on the next edge
- no done_out pulse, no ping_count_out increment
- abort_in takes priority over all other transitions.
REQ-017 SHALL treat abort_in=1 in IDLE as priority over a simultaneous trigger, which is ignored and not counted.
REQ-018 SHALL increment missed_count_out, saturating at 255, for any trigger_in=1 sampled while busy_out=1, including the DRAIN exit cycle.
REQ-019 SHALL ignore triggers with enable_in=0 in IDLE and not count them as missed.
REQ-020 SHALL let a sequence already started complete even if enable_in falls mid-sequence.
REQ-021 SHALL accept a trigger in the first IDLE cycle after completion, i.e. the cycle done_out=1.

Reset
REQ-022 SHALL, while rst_in=1, immediately force:
- state IDLE, counter 0
- all 1-bit outputs 0
- ping_count_out 0, missed_count_out 0
REQ-023 SHALL drop any sequence in progress when reset is asserted mid-sequence, with no done_out pulse.
REQ-024 SHALL start a sequence on the first edge after rst_in deasserts if trigger_in=1 and enable_in=1 on that edge.

Configuration
REQ-025 SHALL compile in the missed-trigger counter when macro PING_SEQ_MISS_COUNT_EN is defined, behaving per REQ-018.
REQ-026 SHALL, when PING_SEQ_MISS_COUNT_EN is undefined, tie missed_count_out to constant 0 with no counter register; all other behaviour is unchanged.

Verification
REQ-027 SHALL cover a nominal ping:
- TX=4, BLANK=3, LISTEN=10, trigger at cycle 0, drain_done_in at cycle 20
- tx_en_out high cycles 1-4, capture_en_out high cycles 8-17, done_out at cycle 21, ping_count_out=1.
REQ-028 SHALL cover zero blanking:
- BLANK=0, TX=4
- capture_en_out rises on the cycle immediately after tx_en_out falls.
REQ-029 SHALL cover abort during LISTEN:
- abort_in at the 5th LISTEN cycle
- busy_out 0 next cycle, done_out never pulses, ping_count_out unchanged.
REQ-030 SHALL cover missed-trigger saturation:
- 300 triggers while held in DRAIN
- missed_count_out=255 with macro defined, 0 with macro undefined.
REQ-031 SHALL cover mid-TX reset:
- rst_in asserted during TX
- tx_en_out 0 without waiting for a clock edge, all counters 0.
REQ-032 SHALL cover back-to-back triggers:
- trigger coincident with drain_done_in is counted missed
- trigger on the done_out cycle starts a new TX.

Source files
------------

// File: rtl/ping_sequencer.sv
// Ping sequencer: IDLE -> TX -> BLANK -> LISTEN -> DRAIN with one shared 20-bit phase counter.
// Optional missed-trigger counter is compiled in with `define PING_SEQ_MISS_COUNT_EN.
module ping_sequencer #(
    parameter int unsigned TX_CYCLES     = 150,
    parameter int unsigned BLANK_CYCLES  = 1500,
    parameter int unsigned LISTEN_CYCLES = 120000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        trigger_in,
    input  logic        abort_in,
    input  logic        drain_done_in,
    output logic        tx_en_out,
    output logic        capture_en_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [15:0] ping_count_out,
    output logic [7:0]  missed_count_out
);

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned PING_W = 16;
    localparam int unsigned MISS_W = 8;

    localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(TX_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
    localparam bit               SKIP_BLANK  = (BLANK_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PING_W-1:0]   ping_q, ping_d;
    logic                done_d;
    logic                tx_en_q, capture_en_q, busy_q, done_q;

    // Next-state logic; abort wins over every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ping_d  = ping_q;
        done_d  = 1'b0;
        if (state_q != S_IDLE && abort_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (trigger_in && enable_in && !abort_in) begin
                        state_d = S_TX;
                    end
                end
                S_TX: begin
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = '0;
                        state_d = SKIP_BLANK ? S_LISTEN : S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = S_LISTEN;
                    end
                end
                S_LISTEN: begin
                    if (cnt_q == LISTEN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    cnt_d = '0;
                    if (drain_done_in) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        ping_d  = ping_q + PING_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters and outputs all update together so outputs track the registered state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ping_q       <= '0;
            tx_en_q      <= 1'b0;
            capture_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ping_q       <= ping_d;
            tx_en_q      <= (state_d == S_TX);
            capture_en_q <= (state_d == S_LISTEN);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= done_d;
        end
    end

    assign tx_en_out      = tx_en_q;
    assign capture_en_out = capture_en_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign ping_count_out = ping_q;

`ifdef PING_SEQ_MISS_COUNT_EN
    logic [MISS_W-1:0] missed_q;

    // Triggers seen while busy, including the DRAIN exit cycle; saturates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            missed_q <= '0;
        end else if (trigger_in && busy_q && missed_q != {MISS_W{1'b1}}) begin
            missed_q <= missed_q + MISS_W'(1);
        end
    end

    assign missed_count_out = missed_q;
`else
    assign missed_count_out = MISS_W'(0);
`endif

endmodule
